// File: rtl/qmult_pkg.sv
// Shared types and constants for the pipelined Q-format multiplier.
// Limits are built wide and narrowed at the point of use.
package qmult_pkg;

  localparam logic RND_TRUNC     = 1'b0;
  localparam logic RND_HALF_AWAY = 1'b1;

  localparam int LIM_W = 256;

  typedef struct packed {
    logic sign;
    logic rnd;
    logic sat;
  } ctl_t;

  function automatic logic [LIM_W-1:0] MAX_POS(input int n);
    return (LIM_W'(1) << (n - 1)) - LIM_W'(1);
  endfunction

  function automatic logic [LIM_W-1:0] MAX_NEG(input int n);
    return LIM_W'(1) << (n - 1);
  endfunction

endpackage

// File: rtl/qmult_round_sat.sv
// Final-stage scaling: shift the product down by Q, optionally round
// half away from zero, detect overflow, then saturate or wrap and re-sign.
module qmult_round_sat #(
  parameter int N = 32,
  parameter int Q = 18
) (
  input  logic           sign,
  input  logic [2*N-1:0] p,
  input  logic           rnd,
  input  logic           sat,
  output logic [N-1:0]   result,
  output logic           ovr
);
  import qmult_pkg::*;

  localparam int MW = 2*N - Q + 1;
  localparam logic [MW-1:0] LIM_POS = MW'(MAX_POS(N));
  localparam logic [MW-1:0] LIM_NEG = MW'(MAX_NEG(N));

  logic          half;
  logic [MW-1:0] m;
  logic          neg;
  logic [N-1:0]  wrap_val;
  logic [N-1:0]  sat_val;

  assign half = (rnd == RND_HALF_AWAY) & p[Q-1];
  assign m    = {1'b0, p[2*N-1:Q]} + MW'(half);

  // A zero magnitude is always reported as +0.
  assign neg  = sign & (m != '0);
  assign ovr  = neg ? (m > LIM_NEG) : (m > LIM_POS);

  assign wrap_val = neg ? (~m[N-1:0] + N'(1)) : m[N-1:0];
  assign sat_val  = neg ? LIM_NEG[N-1:0] : LIM_POS[N-1:0];
  assign result   = (ovr & sat) ? sat_val : wrap_val;

  generate
    if (Q >= 2) begin : g_lo
      logic unused_lo;
      assign unused_lo = ^p[Q-2:0];
    end
  endgenerate

endmodule

// File: rtl/qmult_pipe.sv
// Three-stage signed Q-format multiplier with valid/ready flow control:
// S1 sign/magnitude, S2 unsigned product, S3 round/saturate into the output.
module qmult_pipe #(
  parameter int N = 32,
  parameter int Q = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         rnd_mode,
  input  logic         sat_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] o_result,
  output logic         ovr
);
  import qmult_pkg::*;

  function automatic logic [N-1:0] mag(input logic [N-1:0] v);
    return v[N-1] ? (~v + N'(1)) : v;
  endfunction

  logic           s1_valid;
  ctl_t           s1_ctl;
  logic [N-1:0]   s1_ma;
  logic [N-1:0]   s1_mb;

  logic           s2_valid;
  ctl_t           s2_ctl;
  logic [2*N-1:0] s2_p;

  logic           s2_adv;
  logic           s3_adv;

  logic [N-1:0]   rs_result;
  logic           rs_ovr;

  // Each stage moves when it is empty or its successor moves.
  assign s3_adv   = ~out_valid | out_ready;
  assign s2_adv   = ~s2_valid | s3_adv;
  assign in_ready = ~s1_valid | s2_adv;

  qmult_round_sat #(
    .N (N),
    .Q (Q)
  ) u_round_sat (
    .sign   (s2_ctl.sign),
    .p      (s2_p),
    .rnd    (s2_ctl.rnd),
    .sat    (s2_ctl.sat),
    .result (rs_result),
    .ovr    (rs_ovr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_ctl    <= '0;
      s1_ma     <= '0;
      s1_mb     <= '0;
      s2_valid  <= 1'b0;
      s2_ctl    <= '0;
      s2_p      <= '0;
      out_valid <= 1'b0;
      o_result  <= '0;
      ovr       <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_ctl.sign <= a[N-1] ^ b[N-1];
          s1_ctl.rnd  <= rnd_mode;
          s1_ctl.sat  <= sat_en;
          s1_ma       <= mag(a);
          s1_mb       <= mag(b);
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_ctl <= s1_ctl;
          s2_p   <= {{N{1'b0}}, s1_ma} * {{N{1'b0}}, s1_mb};
        end
      end
      if (s3_adv) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          o_result <= rs_result;
          ovr      <= rs_ovr;
        end
      end
    end
  end

endmodule

// File: tb/tb_qmult_pipe.sv
// Directed and streaming checks for qmult_pipe at N=32, Q=18.
// Expected values are hand-derived constants plus a small longint model.
module tb_qmult_pipe;

  localparam int N = 32;
  localparam int Q = 18;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         rnd_mode = 1'b0;
  logic         sat_en = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] o_result;
  logic         ovr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qmult_pipe #(
    .N (N),
    .Q (Q)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .rnd_mode  (rnd_mode),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o_result  (o_result),
    .ovr       (ovr)
  );

  function automatic logic [32:0] model(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        rnd,
    input logic        sat
  );
    longint      prod;
    logic [63:0] mg;
    logic [63:0] m;
    logic        neg;
    logic        ov;
    logic [31:0] r;
    prod = longint'($signed(x)) * longint'($signed(y));
    mg   = (prod < 0) ? 64'(-prod) : 64'(prod);
    m    = (mg >> 18) + ((rnd && mg[17]) ? 64'd1 : 64'd0);
    neg  = (prod < 0) && (m != 64'd0);
    ov   = neg ? (m > 64'h8000_0000) : (m > 64'h7FFF_FFFF);
    if (ov && sat)
      r = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      r = neg ? 32'(-m) : m[31:0];
    return {ov, r};
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        rnd;
    logic        sat;
    logic        o;
  } vec_t;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold out_valid got %b want 0", out_valid);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (o_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_o_result got %h want 0", o_result);
    end
    checks++;
    if (ovr !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovr got %b want 0", ovr);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_vectors();
    vec_t v[11];
    int   lat;
    v[0]  = '{32'h00060000, 32'hFFF80000, 32'hFFF40000, 1'b0, 1'b1, 1'b0};
    v[1]  = '{32'hFFFE0000, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0};
    v[2]  = '{32'hFFFE0000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
    v[3]  = '{32'h40000000, 32'h40000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
    v[4]  = '{32'h40000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    v[5]  = '{32'h80000000, 32'h00040000, 32'h80000000, 1'b0, 1'b1, 1'b0};
    v[6]  = '{32'h80000000, 32'hFFFC0000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
    v[7]  = '{32'h80000000, 32'hFFFC0000, 32'h80000000, 1'b0, 1'b0, 1'b1};
    v[8]  = '{32'h00020000, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0};
    v[9]  = '{32'h00000000, 32'hFFF80000, 32'h00000000, 1'b1, 1'b1, 1'b0};
    v[10] = '{32'hC0000000, 32'h40000000, 32'h80000000, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      a = v[i].a;
      b = v[i].b;
      rnd_mode = v[i].rnd;
      sat_en = v[i].sat;
      out_ready = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL vec%0d latency got %0d want 3", i, lat);
      end
      checks++;
      if (o_result !== v[i].r) begin
        errors++;
        $display("FAIL vec%0d result got %h want %h", i, o_result, v[i].r);
      end
      checks++;
      if (ovr !== v[i].o) begin
        errors++;
        $display("FAIL vec%0d ovr got %b want %b", i, ovr, v[i].o);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] expq[$];
    logic [31:0] exp_r;
    logic [31:0] prev;
    logic        prev_stall;
    int          acc;
    int          del;
    acc = 0;
    del = 0;
    prev = '0;
    prev_stall = 1'b0;
    rnd_mode = 1'b0;
    sat_en = 1'b1;
    for (int cyc = 0; cyc < 60 && del < 10; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc <= 6);
      in_valid = (acc < 10);
      a = 32'(acc) << 18;
      b = 32'h00080000;
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || o_result !== prev) begin
          errors++;
          $display("FAIL stall_hold cyc%0d got %b/%h want 1/%h",
                   cyc, out_valid, o_result, prev);
        end
      end
      if (cyc == 4) begin
        checks++;
        if (in_ready !== 1'b0 || acc != 3) begin
          errors++;
          $display("FAIL backpressure in_ready=%b pending=%0d want 0/3",
                   in_ready, acc);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        exp_r = (expq.size() > 0) ? expq.pop_front() : 32'hDEADBEEF;
        if (o_result !== exp_r || ovr !== 1'b0) begin
          errors++;
          $display("FAIL stream beat%0d got %h/%b want %h/0",
                   del, o_result, ovr, exp_r);
        end
        del++;
      end
      prev_stall = out_valid && !out_ready;
      prev = o_result;
      if (in_valid && in_ready) begin
        expq.push_back(32'(acc) << 19);
        acc++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (del != 10 || acc != 10) begin
      errors++;
      $display("FAIL stream_count delivered %0d accepted %0d want 10/10",
               del, acc);
    end
  endtask

  task automatic test_reset_flight();
    int lat;
    int stray;
    out_ready = 1'b0;
    rnd_mode = 1'b0;
    sat_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 32'(i + 1) << 18;
      b = 32'h00040000;
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flight_full got %b/%b want out_valid 1 in_ready 0",
               out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || o_result !== 32'h0) begin
      errors++;
      $display("FAIL async_reset got %b/%h want 0/0", out_valid, o_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL stale_result got %0d valid cycles want 0", stray);
    end
    @(negedge clk);
    a = 32'h000C0000;
    b = 32'hFFFC0000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL post_reset_latency got %0d want 3", lat);
    end
    checks++;
    if (o_result !== 32'hFFF40000) begin
      errors++;
      $display("FAIL post_reset_result got %h want fff40000", o_result);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] q[$];
    logic [32:0] exp_v;
    logic [31:0] corner[4];
    logic [31:0] r1;
    logic [31:0] r2;
    int          sent;
    int          got;
    int          first;
    int          last;
    corner[0] = 32'h80000000;
    corner[1] = 32'h7FFFFFFF;
    corner[2] = 32'h00040000;
    corner[3] = 32'hFFFC0000;
    sent = 0;
    got = 0;
    first = -1;
    last = -1;
    for (int cyc = 0; cyc < 80 && got < 40; cyc++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (sent < 40) begin
        r1 = $urandom;
        r2 = $urandom;
        case ($urandom_range(0, 3))
          0: begin a = r1; b = r2; end
          1: begin
            a = {{12{r1[19]}}, r1[19:0]};
            b = {{12{r2[19]}}, r2[19:0]};
          end
          2: begin a = r1; b = {{12{r2[19]}}, r2[19:0]}; end
          default: begin a = corner[r1[1:0]]; b = r2; end
        endcase
        rnd_mode = sent[0];
        sat_en = sent[1];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_in_ready cyc%0d got %b want 1", cyc, in_ready);
        end else begin
          q.push_back(model(a, b, rnd_mode, sat_en));
          sent++;
        end
      end
      if (out_valid) begin
        checks++;
        exp_v = (q.size() > 0) ? q.pop_front() : 33'h0DEADBEEF;
        if ({ovr, o_result} !== exp_v) begin
          errors++;
          $display("FAIL b2b beat%0d got %b/%h want %b/%h",
                   got, ovr, o_result, exp_v[32], exp_v[31:0]);
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 40 || (last - first) != 39) begin
      errors++;
      $display("FAIL b2b_throughput got %0d beats over %0d cycles want 40/40",
               got, last - first + 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_reset_flight();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
